// File: rtl/fios_pkg.sv
// Shared types for the FIOS result collector: word width, word type and FSM state.
package fios_pkg;
  localparam int WORD_W = 17;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_t;
endpackage

// File: rtl/fios_word_sub.sv
// One WORD_W-bit subtract slice with borrow chain; shared across all words of a result.
module fios_word_sub
  import fios_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  logic  bin_i,
  output word_t diff_o,
  output logic  bout_o
);
  assign {bout_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - {{WORD_W{1'b0}}, bin_i};
endmodule

// File: rtl/fios_res_collector.sv
// Assembles the LSW-first FIOS RES stream and presents it on a valid/ready port.
// Optional macro FIOS_FINAL_SUB_EN adds the on-the-fly final subtraction R - p.
module fios_res_collector
  import fios_pkg::*;
#(
  parameter int s = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              res_valid_i,
  input  word_t             res_i,
  input  logic [s*17-1:0]   p_i,
  output logic [s*17-1:0]   result_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic              busy_o,
  output logic              drop_err_o
);
  localparam int W     = s * WORD_W;
  localparam int CNT_W = (s > 1) ? $clog2(s) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(s - 1);

  // Handshake: the result transfers on a cycle where result_valid_o & result_ready_i;
  // result_o and result_valid_o are held stable until then.
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     r_q, r_d;
  logic [W-1:0]     result_q, result_d;
  logic             valid_q;
  logic             drop_q;
  logic             accept;

  // In OUT a word is only taken when the current result leaves in the same cycle.
  assign accept = res_valid_i && ((state_q == COLLECT) || result_ready_i);

  always_comb begin
    r_d = r_q;
    for (int k = 0; k < s; k++) begin
      if (cnt_q == CNT_W'(k)) r_d[k*WORD_W +: WORD_W] = res_i;
    end
  end

`ifdef FIOS_FINAL_SUB_EN
  logic [W-1:0] d_q, d_d;
  logic         borrow_q;
  word_t        p_word;
  word_t        diff;
  logic         bout;
  logic         sub_bin;

  always_comb begin
    p_word = '0;
    for (int k = 0; k < s; k++) begin
      if (cnt_q == CNT_W'(k)) p_word = p_i[k*WORD_W +: WORD_W];
    end
  end

  assign sub_bin = (cnt_q == '0) ? 1'b0 : borrow_q;

  fios_word_sub u_sub (
    .a_i    (res_i),
    .b_i    (p_word),
    .bin_i  (sub_bin),
    .diff_o (diff),
    .bout_o (bout)
  );

  always_comb begin
    d_d = d_q;
    for (int k = 0; k < s; k++) begin
      if (cnt_q == CNT_W'(k)) d_d[k*WORD_W +: WORD_W] = diff;
    end
  end

  // A final borrow means R < p, so the raw value is already reduced.
  assign result_d = bout ? r_d : d_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      d_q      <= d_d;
      borrow_q <= bout;
    end
  end
`else
  logic p_unused;
  assign p_unused = ^p_i;
  assign result_d = r_d;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      r_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (res_valid_i && !accept) drop_q <= 1'b1;
      if (accept) begin
        r_q   <= r_d;
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
        COLLECT: begin
          if (accept && (cnt_q == LAST)) begin
            state_q  <= OUT;
            valid_q  <= 1'b1;
            result_q <= result_d;
          end
        end
        OUT: begin
          if (result_ready_i) begin
            state_q <= COLLECT;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q == COLLECT) && (cnt_q != '0);
  assign drop_err_o     = drop_q;
endmodule

// File: tb/tb_fios_res_collector.sv
// Directed bench for fios_res_collector (s=8); expectations follow FIOS_FINAL_SUB_EN.
module tb_fios_res_collector;
  import fios_pkg::*;

  localparam int S = 8;
  localparam int W = S * WORD_W;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         res_valid_i = 1'b0;
  word_t        res_i = '0;
  logic [W-1:0] p_i = '0;
  logic [W-1:0] result_o;
  logic         result_valid_o;
  logic         result_ready_i = 1'b0;
  logic         busy_o;
  logic         drop_err_o;

  int n_vec = 0;
  int n_err = 0;

  fios_res_collector #(.s(S)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .res_valid_i    (res_valid_i),
    .res_i          (res_i),
    .p_i            (p_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .busy_o         (busy_o),
    .drop_err_o     (drop_err_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [W-1:0] exp_res(input logic [W-1:0] r, input logic [W-1:0] p);
`ifdef FIOS_FINAL_SUB_EN
    return (r >= p) ? r - p : r;
`else
    return r;
`endif
  endfunction

  function automatic word_t wd(input logic [W-1:0] v, input int k);
    return v[k*WORD_W +: WORD_W];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic drive(input logic v, input word_t w);
    res_valid_i = v;
    res_i       = w;
    @(posedge clock_i);
    #1;
    res_valid_i = 1'b0;
  endtask

  task automatic send_stream(input string tag, input logic [W-1:0] r);
    for (int k = 0; k < S; k++) begin
      drive(1'b1, wd(r, k));
      if (k == 0) chk({tag, "_busy"}, W'(busy_o), W'(1));
      if (k < S - 1) chk({tag, "_early_valid"}, W'(result_valid_o), W'(0));
    end
    chk({tag, "_valid"}, W'(result_valid_o), W'(1));
    chk({tag, "_idle"}, W'(busy_o), W'(0));
  endtask

  task automatic handshake(input string tag);
    result_ready_i = 1'b1;
    drive(1'b0, '0);
    result_ready_i = 1'b0;
    chk({tag, "_valid_fall"}, W'(result_valid_o), W'(0));
  endtask

  logic [W-1:0] p_big, r1, r2;

  initial begin
    repeat (2) @(posedge clock_i);
    #1;
    chk("rst_valid", W'(result_valid_o), W'(0));
    chk("rst_busy", W'(busy_o), W'(0));
    chk("rst_drop", W'(drop_err_o), W'(0));
    chk("rst_result", result_o, '0);
    reset_i = 1'b0;

    p_i = W'(5);
    send_stream("r7", W'(7));
    chk("r7_result", result_o, exp_res(W'(7), W'(5)));
    handshake("r7");

    send_stream("r3", W'(3));
    chk("r3_result", result_o, exp_res(W'(3), W'(5)));
    handshake("r3");
    send_stream("r5", W'(5));
    chk("r5_result", result_o, exp_res(W'(5), W'(5)));
    handshake("r5");

    p_i = (W'(1) << WORD_W) | W'(1);
    send_stream("xb", (W'(1) << WORD_W) | W'(17'h1FFFF));
    chk("xb_result", result_o, exp_res((W'(1) << WORD_W) | W'(17'h1FFFF), p_i));
    handshake("xb");

    p_big = {17'h0F123, 17'h1ABCD, 17'h00045, 17'h1FFFF,
             17'h12345, 17'h00000, 17'h0BEEF, 17'h1C001};
    p_i = p_big;
    r1  = p_big + W'(1000);
    r2  = p_big - W'(1);
    result_ready_i = 1'b1;
    for (int k = 0; k < S; k++) begin
      drive(1'b1, wd(r1, k));
      if (k < S - 1) drive(1'b0, '0);
    end
    chk("gap_valid", W'(result_valid_o), W'(1));
    chk("gap_result", result_o, exp_res(r1, p_big));
    drive(1'b1, wd(r2, 0));
    chk("b2b_valid_fall", W'(result_valid_o), W'(0));
    chk("b2b_busy", W'(busy_o), W'(1));
    for (int k = 1; k < S; k++) drive(1'b1, wd(r2, k));
    chk("b2b_valid", W'(result_valid_o), W'(1));
    chk("b2b_result", result_o, exp_res(r2, p_big));
    drive(1'b0, '0);
    result_ready_i = 1'b0;
    chk("b2b_done", W'(result_valid_o), W'(0));
    chk("b2b_nodrop", W'(drop_err_o), W'(0));

    p_i = W'(5);
    send_stream("dr", W'(7));
    drive(1'b1, 17'h01234);
    chk("dr_drop", W'(drop_err_o), W'(1));
    chk("dr_hold_valid", W'(result_valid_o), W'(1));
    chk("dr_hold_result", result_o, exp_res(W'(7), W'(5)));
    handshake("dr");
    chk("dr_sticky", W'(drop_err_o), W'(1));

    for (int k = 0; k < 3; k++) drive(1'b1, wd(W'(9), k));
    reset_i = 1'b1;
    drive(1'b1, wd(W'(9), 3));
    reset_i = 1'b0;
    chk("mr_valid", W'(result_valid_o), W'(0));
    chk("mr_busy", W'(busy_o), W'(0));
    chk("mr_drop", W'(drop_err_o), W'(0));
    chk("mr_result", result_o, '0);
    send_stream("pr", W'(9));
    chk("pr_result", result_o, exp_res(W'(9), W'(5)));
    handshake("pr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fios_res_collector.md
Name: fios_res_collector

Overview:
- Receiving end of the FIOS Montgomery multiplier's serial result port.
- Takes the least-significant-word-first 17-bit RES stream (s words per multiplication) and assembles the full-width result.
- Performs the conditional final subtraction R − p on the fly, so the output is fully reduced (< p).
- Presents the result on a valid/ready handshake to the downstream consumer, e.g. an exponentiation controller or host bus bridge.

Parameters:
- s, 8, number of 17-bit words per operand/result; must match the multiplier's s.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- res_valid_i  in  1  RES word present this cycle; the multiplier cannot stall
- res_i  in  17  RES word, LSW first
- p_i  in  s*17  modulus; held stable from first word until result handshake
- result_o  out  s*17  reduced result, valid when result_valid_o=1
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts result
- busy_o  out  1  at least one word of the current result collected, not yet presented
- drop_err_o  out  1  sticky: a RES word was discarded

Behaviour:
- Reset values: result_valid_o=0, busy_o=0, drop_err_o=0, result_o=0; word counter=0; borrow=0; state=COLLECT.
- Reset mid-operation discards any partial result.
- States: COLLECT, OUT.
- COLLECT, word acceptance: each cycle with res_valid_i=1 accepts word k (k = counter 0..s-1):
  - stores R[k]=res_i;
  - computes {b_out, D[k]} = res_i − p_i[k*17+:17] − borrow; the borrow-in is 0 for k=0;
  - registers b_out as the new borrow.
- COLLECT, gaps: res_valid_i=0 cycles are allowed and hold all state.
- COLLECT → OUT: the cycle word s−1 is accepted, the counter wraps to 0 and the state moves to OUT.
  - result_valid_o rises one cycle after the last word is sampled (1-cycle latency).
- OUT, selection: result_o = borrow ? R : D. borrow=1 means R<p. R=p yields 0.
  - The input guarantee is R < 2p, so one subtraction always suffices.
- OUT, hold: result_o and result_valid_o stay stable until result_valid_o & result_ready_i.
- OUT, handshake: result_valid_o falls the next cycle; the state returns to COLLECT.
- OUT, simultaneous res_valid_i=1 in the handshake cycle: that word is accepted as word 0 (counter becomes 1). This supports back-to-back multiplications.
- OUT, res_valid_i=1 without the handshake: the word is discarded, drop_err_o sets, and the stored result is unchanged.
- drop_err_o clears only on reset.
- busy_o = (state==COLLECT && counter!=0).
- Width rule: D and R are each s*17 bits; the final borrow is a separate 1-bit flop; no wider arithmetic is used.

Optional Feature:
- Macro: FIOS_FINAL_SUB_EN.
- Defined: the D register file, per-word subtractor and borrow flop are present; result_o is fully reduced as described above.
- Undefined: the subtraction logic is removed; result_o = R (the raw Montgomery result, < 2p). p_i is ignored, and timing and handshake are otherwise identical.

Decomposition:
- Package fios_pkg holds:
  - localparam WORD_W=17;
  - typedef logic [WORD_W-1:0] word_t;
  - the state enum (COLLECT, OUT).
- Sub-module fios_word_sub: combinational WORD_W-bit subtract with borrow-in/borrow-out, instantiated once and time-shared across words.

Test Plan:
- p=5 (word0=5, others 0), stream R=7 (word0=7, others 0) → result_o=2; result_valid_o high exactly one cycle after word 7 is sampled.
- p=5, R=3 → result_o=3; R=5 → result_o=0.
- Cross-word borrow: p words {1,1}, R words {0x1FFFF,1}, upper words 0 → result_o=0x1FFFE.
- Gapped input (res_valid_i toggling 1,0,1,...) with result_ready_i=1 held, followed by a second stream starting in the handshake cycle → both results correct, no drop_err_o.
- result_ready_i=0 while res_valid_i pulses in OUT → drop_err_o=1, result_o unchanged; reset_i in the middle of word 3 of the next stream → all outputs 0, and the following full stream produces the correct result.
- Build without FIOS_FINAL_SUB_EN, p=5, R=7 → result_o=7.
